// File: rtl/bit_frame_rx.sv
// rtl/bit_frame_rx.sv - framed word receiver for the registered single-bit link
//
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-low reset
//   in_bit, in_stat  serial bit (idle 1) and its complement status
//   out_data         received word, stable while out_valid = 1
//   out_valid        holding register holds an unconsumed word
//   out_ready        consumer accepts out_data when out_valid & out_ready
//   pair_err         one-cycle pulse: in_stat == in_bit
//   frame_err        one-cycle pulse: stop bit sampled as 0
//   parity_err       one-cycle pulse: even parity mismatch
//   overrun          one-cycle pulse: completed word dropped, holding register full
//   err_cnt          saturating count of all error pulses
module bit_frame_rx #(
    parameter int DATA_W = 8,
    parameter int PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic              in_stat,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              pair_err,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic [7:0]        err_cnt
);

    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par_bad, par_bad_n;

    logic              pair_ok;
    logic              complete;
    logic              pair_n, frame_n, parity_n, ovr_n;
    logic              load;
    logic [8:0]        err_sum;

    assign pair_ok = (in_stat != in_bit);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        par_bad_n = par_bad;
        complete  = 1'b0;
        pair_n    = 1'b0;
        frame_n   = 1'b0;
        parity_n  = 1'b0;

        if (!pair_ok) begin
            // A corrupt pair aborts any frame and is ignored otherwise.
            pair_n  = 1'b1;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!in_bit) begin
                        state_n   = DATA;
                        cnt_n     = '0;
                        shreg_n   = '0;
                        par_bad_n = 1'b0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shift right from the MSB end.
                    shreg_n = {in_bit, shreg[DATA_W-1:1]};
                    cnt_n   = cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1))
                        state_n = (PARITY != 0) ? PAR : STOP;
                end
                PAR: begin
                    par_bad_n = (in_bit != ^shreg);
                    state_n   = STOP;
                end
                STOP: begin
                    // A 0 here is a framing error, never a start bit.
                    state_n  = IDLE;
                    frame_n  = !in_bit;
                    parity_n = par_bad;
                    complete = in_bit && !par_bad;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign load    = complete && (!out_valid || out_ready);
    assign ovr_n   = complete && out_valid && !out_ready;
    assign err_sum = {1'b0, err_cnt} + 9'(pair_n) + 9'(frame_n) + 9'(parity_n) + 9'(ovr_n);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            pair_err   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            par_bad    <= par_bad_n;
            pair_err   <= pair_n;
            frame_err  <= frame_n;
            parity_err <= parity_n;
            overrun    <= ovr_n;
            err_cnt    <= (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
            if (load) begin
                out_data  <= shreg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
